// File: rtl/div_8por4_bits.sv
// div_8por4_bits: sequential restoring divider, one quotient bit per clock, with divide-by-zero flag
module div_8por4_bits #(
    parameter int DIVIDEND_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DIVIDEND_WIDTH-1:0] A_i,
    input  logic [DIVISOR_WIDTH-1:0]  B_i,
    input  logic                      en_i,
    output logic [2:0]                estado_o,
    output logic [DIVIDEND_WIDTH-1:0] Q_o,
    output logic [DIVISOR_WIDTH-1:0]  R_o,
    output logic                      fim_o,
    output logic                      erro_o
);
    localparam int CW = $clog2(DIVIDEND_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDEND_WIDTH - 1);
    typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_CALC = 3'd1, ST_END = 3'd2, ST_DIVZ = 3'd3} state_t;
    state_t state;
    logic [DIVIDEND_WIDTH-1:0] dvd, new_dvd;
    logic [DIVISOR_WIDTH-1:0]  dvs;
    logic [DIVISOR_WIDTH:0]    rem, new_rem;
    logic [DIVISOR_WIDTH+1:0]  rem_sh, trial;
    logic [CW-1:0]             cnt;
    logic                      ge;
    // The extra top bit of trial is the borrow: clear means the subtraction fits
    assign rem_sh   = {rem, dvd[DIVIDEND_WIDTH-1]};
    assign trial    = rem_sh - {2'b00, dvs};
    assign ge       = ~trial[DIVISOR_WIDTH+1];
    assign new_rem  = ge ? trial[DIVISOR_WIDTH:0] : rem_sh[DIVISOR_WIDTH:0];
    assign new_dvd  = {dvd[DIVIDEND_WIDTH-2:0], ge};
    assign estado_o = state;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            Q_o    <= '0;
            R_o    <= '0;
            fim_o  <= 1'b0;
            erro_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (en_i) begin
                    if (B_i != '0) begin
                        dvd   <= A_i;
                        dvs   <= B_i;
                        rem   <= '0;
                        cnt   <= '0;
                        Q_o   <= '0;
                        R_o   <= '0;
                        state <= ST_CALC;
                    end else begin
                        Q_o    <= '1;
                        R_o    <= '0;
                        fim_o  <= 1'b1;
                        erro_o <= 1'b1;
                        state  <= ST_DIVZ;
                    end
                end
                ST_CALC: begin
                    dvd <= new_dvd;
                    rem <= new_rem;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Q_o   <= new_dvd;
                        R_o   <= new_rem[DIVISOR_WIDTH-1:0];
                        fim_o <= 1'b1;
                        state <= ST_END;
                    end
                end
                ST_END: if (!en_i) begin
                    fim_o <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_DIVZ: if (!en_i) begin
                    fim_o  <= 1'b0;
                    erro_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    fim_o  <= 1'b0;
                    erro_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_8por4_bits.sv
// tb_div_8por4_bits: directed scoreboard bench for the restoring divider
module tb_div_8por4_bits;
    logic       clk_i = 1'b0;
    logic       rst_i, en_i, fim_o, erro_o;
    logic [7:0] A_i, Q_o;
    logic [3:0] B_i, R_o;
    logic [2:0] estado_o;
    int tests = 0;
    int fails = 0;
    typedef struct {logic [7:0] q; logic [3:0] r;} exp_t;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    div_8por4_bits dut (
        .clk_i(clk_i), .rst_i(rst_i), .A_i(A_i), .B_i(B_i), .en_i(en_i),
        .estado_o(estado_o), .Q_o(Q_o), .R_o(R_o), .fim_o(fim_o), .erro_o(erro_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        A_i  = a;
        B_i  = b;
        en_i = 1'b1;
        if (b != 4'd0) begin
            e.q = a / {4'd0, b};
            e.r = 4'(a % {4'd0, b});
            sb.push_back(e);
        end
        @(negedge clk_i);
    endtask

    task automatic finish_op(input string tag, input bit pulse, input bit rnd, input bit hold);
        int   k;
        exp_t e;
        if (pulse) en_i = 1'b0;
        k = 0;
        while (!fim_o && k < 20) begin
            chk({tag, " calc_state"}, 32'(estado_o), 32'd1);
            if (rnd) begin
                A_i  = 8'($urandom);
                B_i  = 4'($urandom);
                en_i = 1'($urandom);
            end
            @(negedge clk_i);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'd8);
        chk({tag, " end_state"}, 32'(estado_o), 32'd2);
        chk({tag, " erro"}, 32'(erro_o), 32'd0);
        if (sb.size() == 0) begin
            e.q = 8'd0;
            e.r = 4'd0;
            chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else e = sb.pop_front();
        chk({tag, " Q"}, 32'(Q_o), 32'(e.q));
        chk({tag, " R"}, 32'(R_o), 32'(e.r));
        if (hold) begin
            en_i = 1'b1;
            repeat (3) begin
                @(negedge clk_i);
                chk({tag, " hold_state"}, 32'(estado_o), 32'd2);
                chk({tag, " hold_fim"}, 32'(fim_o), 32'd1);
                chk({tag, " hold_Q"}, 32'(Q_o), 32'(e.q));
                chk({tag, " hold_R"}, 32'(R_o), 32'(e.r));
            end
        end
        en_i = 1'b0;
        @(negedge clk_i);
        chk({tag, " idle_state"}, 32'(estado_o), 32'd0);
        chk({tag, " idle_fim"}, 32'(fim_o), 32'd0);
        chk({tag, " idle_Q"}, 32'(Q_o), 32'(e.q));
        chk({tag, " idle_R"}, 32'(R_o), 32'(e.r));
    endtask

    initial begin
        rst_i = 1'b1;
        en_i  = 1'b0;
        A_i   = 8'd0;
        B_i   = 4'd0;
        repeat (2) @(negedge clk_i);
        chk("rst state", 32'(estado_o), 32'd0);
        chk("rst Q", 32'(Q_o), 32'd0);
        chk("rst R", 32'(R_o), 32'd0);
        chk("rst fim", 32'(fim_o), 32'd0);
        chk("rst erro", 32'(erro_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        start(8'd200, 4'd7);
        finish_op("200/7", 1'b1, 1'b0, 1'b0);
        start(8'd255, 4'd1);
        finish_op("255/1", 1'b0, 1'b0, 1'b0);
        start(8'd255, 4'd15);
        finish_op("255/15", 1'b0, 1'b0, 1'b0);
        start(8'd13, 4'd14);
        finish_op("13/14", 1'b1, 1'b0, 1'b0);

        start(8'd100, 4'd0);
        repeat (3) begin
            chk("divz state", 32'(estado_o), 32'd3);
            chk("divz fim", 32'(fim_o), 32'd1);
            chk("divz erro", 32'(erro_o), 32'd1);
            chk("divz Q", 32'(Q_o), 32'hFF);
            chk("divz R", 32'(R_o), 32'd0);
            @(negedge clk_i);
        end
        en_i = 1'b0;
        @(negedge clk_i);
        chk("divz idle_state", 32'(estado_o), 32'd0);
        chk("divz idle_erro", 32'(erro_o), 32'd0);
        chk("divz idle_fim", 32'(fim_o), 32'd0);

        // Abort on the fourth CALC edge while en_i is still high
        A_i  = 8'd200;
        B_i  = 4'd7;
        en_i = 1'b1;
        @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("abort state", 32'(estado_o), 32'd0);
        chk("abort Q", 32'(Q_o), 32'd0);
        chk("abort R", 32'(R_o), 32'd0);
        chk("abort fim", 32'(fim_o), 32'd0);
        rst_i = 1'b0;
        en_i  = 1'b0;
        @(negedge clk_i);
        start(8'd50, 4'd6);
        finish_op("50/6", 1'b0, 1'b0, 1'b0);

        start(8'd99, 4'd10);
        finish_op("99/10", 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
